// File: rtl/sw_debounce_bank.sv
// rtl/sw_debounce_bank.sv - N-channel switch synchroniser, debouncer and edge-pulse generator.
// Optional push-on/push-off latch outputs enabled by defining SW_DEBOUNCE_TOGGLE_EN.
module sw_debounce_bank #(
  parameter int N_SW          = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_in,
  output logic [N_SW-1:0] sw_db,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
`ifdef SW_DEBOUNCE_TOGGLE_EN
  output logic [N_SW-1:0] sw_toggle,
`endif
  output logic            any_change
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][N_SW-1:0] sync_q;
  logic [N_SW-1:0]                  sync;
  logic [CNT_W-1:0]                 cnt [N_SW];
  logic [N_SW-1:0]                  accept;
  logic [N_SW-1:0]                  rise_d;
  logic [N_SW-1:0]                  fall_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // A channel is accepted on the edge where it has already disagreed for STABLE_CYCLES-1 cycles.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_SW; i++) begin
      accept[i] = (sync[i] != sw_db[i]) && (cnt[i] == CNT_MAX);
    end
    rise_d = accept & sync;
    fall_d = accept & ~sync;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SW; i++) begin
        cnt[i] <= '0;
      end
      sw_db   <= '0;
      sw_rise <= '0;
      sw_fall <= '0;
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        if (sync[i] == sw_db[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      sw_db   <= (sw_db & ~accept) | (sync & accept);
      sw_rise <= rise_d;
      sw_fall <= fall_d;
    end
  end

  assign any_change = |(sw_rise | sw_fall);

`ifdef SW_DEBOUNCE_TOGGLE_EN
  // Flips on the same edge that raises sw_rise, so both become visible together.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_toggle <= '0;
    end else begin
      sw_toggle <= sw_toggle ^ rise_d;
    end
  end
`endif

endmodule

// File: tb/tb_sw_debounce_bank.sv
// tb/tb_sw_debounce_bank.sv - directed self-checking bench for sw_debounce_bank (default parameters).
module tb_sw_debounce_bank;

  logic       clk;
  logic       rst;
  logic [1:0] sw_in;
  logic [1:0] sw_db;
  logic [1:0] sw_rise;
  logic [1:0] sw_fall;
  logic       any_change;
`ifdef SW_DEBOUNCE_TOGGLE_EN
  logic [1:0] sw_toggle;
`endif

  int checks = 0;
  int errors = 0;

  sw_debounce_bank #(
    .N_SW(2), .SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_in(sw_in),
    .sw_db(sw_db),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
`ifdef SW_DEBOUNCE_TOGGLE_EN
    .sw_toggle(sw_toggle),
`endif
    .any_change(any_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_db"},   32'(sw_db),      32'd0);
    chk({tag, "_rise"}, 32'(sw_rise),    32'd0);
    chk({tag, "_fall"}, 32'(sw_fall),    32'd0);
    chk({tag, "_any"},  32'(any_change), 32'd0);
  endtask

  // Run n edges; at edge number edge_at expect the new level and the given pulses, quiet elsewhere.
  task automatic settle(input int n, input int edge_at, input logic [1:0] db0, input logic [1:0] db1,
                        input logic [1:0] rise, input logic [1:0] fall, input string tag);
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == edge_at) begin
        chk({tag, "_db_edge"},   32'(sw_db),      32'(db1));
        chk({tag, "_rise_edge"}, 32'(sw_rise),    32'(rise));
        chk({tag, "_fall_edge"}, 32'(sw_fall),    32'(fall));
        chk({tag, "_any_edge"},  32'(any_change), 32'(|(rise | fall)));
      end else begin
        chk({tag, "_db"},   32'(sw_db),      32'((k < edge_at) ? db0 : db1));
        chk({tag, "_rise"}, 32'(sw_rise),    32'd0);
        chk({tag, "_fall"}, 32'(sw_fall),    32'd0);
        chk({tag, "_any"},  32'(any_change), 32'd0);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    sw_in = 2'b11;
    tick();
    chk_all_zero("rst_c1");
    tick();
    chk_all_zero("rst_c2");
`ifdef SW_DEBOUNCE_TOGGLE_EN
    chk("rst_toggle", 32'(sw_toggle), 32'd0);
`endif

    rst = 1'b0;
    settle(8, 6, 2'b00, 2'b11, 2'b11, 2'b00, "rst_rel");
`ifdef SW_DEBOUNCE_TOGGLE_EN
    chk("toggle_after_rst_rel", 32'(sw_toggle), 32'd3);
`endif

    sw_in = 2'b00;
    settle(8, 6, 2'b11, 2'b00, 2'b00, 2'b11, "all_low");

    sw_in = 2'b01;
    settle(10, 6, 2'b00, 2'b01, 2'b01, 2'b00, "press0");
`ifdef SW_DEBOUNCE_TOGGLE_EN
    chk("toggle_after_press0", 32'(sw_toggle), 32'd2);
`endif
    sw_in = 2'b00;
    settle(10, 6, 2'b01, 2'b00, 2'b00, 2'b01, "release0");
`ifdef SW_DEBOUNCE_TOGGLE_EN
    chk("toggle_after_release0", 32'(sw_toggle), 32'd2);
`endif

    sw_in = 2'b10;
    settle(3, 0, 2'b00, 2'b00, 2'b00, 2'b00, "glitch3_hi");
    sw_in = 2'b00;
    settle(8, 0, 2'b00, 2'b00, 2'b00, 2'b00, "glitch3_lo");

    // Four high samples: accepted on edge 6, then the drop is accepted on edge 10.
    sw_in = 2'b10;
    settle(4, 0, 2'b00, 2'b00, 2'b00, 2'b00, "g4_hi");
    sw_in = 2'b00;
    settle(2, 2, 2'b00, 2'b10, 2'b10, 2'b00, "g4_rise");
    settle(4, 4, 2'b10, 2'b00, 2'b00, 2'b10, "g4_fall");
    settle(3, 0, 2'b00, 2'b00, 2'b00, 2'b00, "g4_idle");
`ifdef SW_DEBOUNCE_TOGGLE_EN
    chk("toggle_after_g4", 32'(sw_toggle), 32'd0);
`endif

    sw_in = 2'b01; settle(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, "bounce_a");
    sw_in = 2'b00; settle(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, "bounce_b");
    sw_in = 2'b01; settle(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, "bounce_c");
    sw_in = 2'b00; settle(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, "bounce_d");
    sw_in = 2'b01;
    settle(10, 6, 2'b00, 2'b01, 2'b01, 2'b00, "bounce_hold");
`ifdef SW_DEBOUNCE_TOGGLE_EN
    chk("toggle_after_bounce", 32'(sw_toggle), 32'd1);
`endif
    sw_in = 2'b00;
    settle(8, 6, 2'b01, 2'b00, 2'b00, 2'b01, "bounce_rel");

    sw_in = 2'b01;
    settle(4, 0, 2'b00, 2'b00, 2'b00, 2'b00, "pre_rst");
    rst = 1'b1;
    tick();
    chk_all_zero("mid_rst");
`ifdef SW_DEBOUNCE_TOGGLE_EN
    chk("mid_rst_toggle", 32'(sw_toggle), 32'd0);
`endif
    rst = 1'b0;
    settle(8, 6, 2'b00, 2'b01, 2'b01, 2'b00, "post_rst");
`ifdef SW_DEBOUNCE_TOGGLE_EN
    chk("toggle_after_post_rst", 32'(sw_toggle), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
